// File: rtl/neuron_accumulator_pkg.sv
// Shared definitions for the neuron accumulator and its adder controller:
// default datapath widths, FSM state encodings and a small width helper.
package neuron_accumulator_pkg;

    localparam int NA_DATA_W = 16;
    localparam int NA_ACC_W  = 24;
    localparam int NA_IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } na_state_e;

    // Wider of two operand widths, used to size an overflow-free sum.
    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neuron_accumulator_sat_add.sv
// Combinational saturating adder: adds two signed operands of arbitrary
// widths and clamps the exact sum into the signed OUT_W range.
module sat_add
    import neuron_accumulator_pkg::*;
#(
    parameter int A_W   = 24,
    parameter int B_W   = 32,
    parameter int OUT_W = 24
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [OUT_W-1:0] y
);

    // One guard bit above the wider operand makes the sum exact.
    localparam int SUM_W = max_width(A_W, B_W) + 1;

    logic signed [SUM_W-1:0]     sum;
    logic        [SUM_W-OUT_W:0] top_bits;

    // Exact sum, then clamp when the bits above the result sign disagree.
    always_comb begin
        sum      = SUM_W'(a) + SUM_W'(b);
        top_bits = sum[SUM_W-1:OUT_W-1];
        if ((&top_bits) || !(|top_bits)) begin
            y = sum[OUT_W-1:0];
        end else if (sum[SUM_W-1]) begin
            y = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            y = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron multiply-accumulate engine: one product per startAdd handshake,
// saturating accumulation, index generation for the sample/weight memories.
module neuron_accumulator
    import neuron_accumulator_pkg::*;
#(
    parameter int DATA_W = NA_DATA_W,
    parameter int ACC_W  = NA_ACC_W,
    parameter int IDX_W  = NA_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [IDX_W-1:0]         numInputs,
    input  logic                     startAdd,
    output logic [IDX_W-1:0]         idx,
    input  logic signed [DATA_W-1:0] inData,
    input  logic signed [DATA_W-1:0] weight,
    output logic                     sinAddFin,
    output logic                     lastAdd,
    output logic signed [ACC_W-1:0]  accOut
);

    localparam int PROD_W = 2 * DATA_W;

    na_state_e                 state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          num_q, num_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [PROD_W-1:0]  product_q, product_d;
    logic                      fin_q, fin_d;
    logic signed [ACC_W-1:0]   sat_sum;
    logic                      last_add;

    sat_add #(
        .A_W   (ACC_W),
        .B_W   (PROD_W),
        .OUT_W (ACC_W)
    ) u_sat_add (
        .a (acc_q),
        .b (product_q),
        .y (sat_sum)
    );

    // Decoded purely from registers so lastAdd has no input-to-output path.
    assign last_add = (idx_q == num_q);

    // Next-state logic; clear overrides everything and aborts any step.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        num_d     = num_q;
        acc_d     = acc_q;
        product_d = product_q;
        fin_d     = 1'b0;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
            num_d   = numInputs;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startAdd && !last_add) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    product_d = PROD_W'(inData) * PROD_W'(weight);
                    state_d   = MAC;
                end
                MAC: begin
                    acc_d   = sat_sum;
                    idx_d   = idx_q + 1'b1;
                    fin_d   = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            fin_q     <= fin_d;
        end
    end

    assign idx       = idx_q;
    assign accOut    = acc_q;
    assign sinAddFin = fin_q;
    assign lastAdd   = last_add;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator.
module tb_neuron_accumulator;

    logic               clk;
    logic               rst;
    logic               clear;
    logic [4:0]         numInputs;
    logic               startAdd;
    logic [4:0]         idx;
    logic signed [15:0] inData;
    logic signed [15:0] weight;
    logic               sinAddFin;
    logic               lastAdd;
    logic signed [23:0] accOut;

    logic signed [15:0] samp_mem [0:31];
    logic signed [15:0] wgt_mem  [0:31];

    int checks;
    int failures;

    neuron_accumulator #(
        .DATA_W (16),
        .ACC_W  (24),
        .IDX_W  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .numInputs (numInputs),
        .startAdd  (startAdd),
        .idx       (idx),
        .inData    (inData),
        .weight    (weight),
        .sinAddFin (sinAddFin),
        .lastAdd   (lastAdd),
        .accOut    (accOut)
    );

    // Memories are read combinationally, so data is stable well before FETCH.
    assign inData = samp_mem[idx];
    assign weight = wgt_mem[idx];

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some wait never terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            samp_mem[i] = '0;
            wgt_mem[i]  = '0;
        end
    endtask

    task automatic do_clear(input logic [4:0] n);
        clear     = 1'b1;
        numInputs = n;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Starts one step and returns the number of edges until sinAddFin, or -1.
    task automatic run_step(output int cyc);
        startAdd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startAdd = 1'b0;
        cyc = 1;
        while (sinAddFin !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (sinAddFin !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (idx !== 5'd0) begin failures++; $display("[TB] FAIL reset_idx got=%0d exp=0", idx); end
        checks++; if (accOut !== 24'sd0) begin failures++; $display("[TB] FAIL reset_acc got=%0d exp=0", accOut); end
        checks++; if (sinAddFin !== 1'b0) begin failures++; $display("[TB] FAIL reset_fin got=%b exp=0", sinAddFin); end
        checks++; if (lastAdd !== 1'b1) begin failures++; $display("[TB] FAIL reset_last got=%b exp=1", lastAdd); end
        @(negedge clk);
        rst = 1'b1;
        startAdd = 1'b1;
        begin
            int pulses = 0;
            repeat (6) begin
                @(negedge clk);
                if (sinAddFin === 1'b1) pulses++;
            end
            startAdd = 1'b0;
            checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL reset_idle_pulses got=%0d exp=0", pulses); end
            checks++; if (idx !== 5'd0) begin failures++; $display("[TB] FAIL reset_idle_idx got=%0d exp=0", idx); end
        end
    endtask

    task automatic test_basic();
        int cyc;
        int exp_acc [3] = '{10, -8, 20};
        logic exp_last [3] = '{1'b0, 1'b0, 1'b1};
        clear_mem();
        samp_mem[0] = 16'sd2;  wgt_mem[0] = 16'sd5;
        samp_mem[1] = -16'sd3; wgt_mem[1] = 16'sd6;
        samp_mem[2] = 16'sd4;  wgt_mem[2] = 16'sd7;
        do_clear(5'd3);
        numInputs = 5'd7;
        checks++; if (accOut !== 24'sd0) begin failures++; $display("[TB] FAIL basic_clear_acc got=%0d exp=0", accOut); end
        checks++; if (lastAdd !== 1'b0) begin failures++; $display("[TB] FAIL basic_clear_last got=%b exp=0", lastAdd); end
        for (int i = 0; i < 3; i++) begin
            run_step(cyc);
            checks++; if (cyc != 3) begin failures++; $display("[TB] FAIL basic_latency[%0d] got=%0d exp=3", i, cyc); end
            checks++; if (accOut !== exp_acc[i]) begin failures++; $display("[TB] FAIL basic_acc[%0d] got=%0d exp=%0d", i, accOut, exp_acc[i]); end
            checks++; if (idx !== 5'(i + 1)) begin failures++; $display("[TB] FAIL basic_idx[%0d] got=%0d exp=%0d", i, idx, i + 1); end
            checks++; if (lastAdd !== exp_last[i]) begin failures++; $display("[TB] FAIL basic_last[%0d] got=%b exp=%b", i, lastAdd, exp_last[i]); end
            @(negedge clk);
            checks++; if (sinAddFin !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse_width[%0d] got=%b exp=0", i, sinAddFin); end
        end
        numInputs = 5'd0;
    endtask

    task automatic test_saturation();
        int cyc;
        int exp_acc [10] = '{8388607, 8388607, 8388607, 8388607, 8388607,
                             8388607, 8388607, 8388607, -8388608, 8388607};
        int exp_edge [3] = '{8388352, 8388607, 8388607};
        clear_mem();
        for (int i = 0; i < 8; i++) begin
            samp_mem[i] = 16'sd32767;
            wgt_mem[i]  = 16'sd32767;
        end
        samp_mem[8] = 16'sd32767; wgt_mem[8] = -16'sd32768;
        samp_mem[9] = 16'sd32767; wgt_mem[9] = 16'sd32767;
        do_clear(5'd10);
        for (int i = 0; i < 10; i++) begin
            run_step(cyc);
            checks++; if (accOut !== exp_acc[i]) begin failures++; $display("[TB] FAIL sat_acc[%0d] got=%0d exp=%0d", i, accOut, exp_acc[i]); end
            @(negedge clk);
        end
        clear_mem();
        samp_mem[0] = 16'sd32767; wgt_mem[0] = 16'sd256;
        samp_mem[1] = 16'sd255;   wgt_mem[1] = 16'sd1;
        samp_mem[2] = 16'sd1;     wgt_mem[2] = 16'sd1;
        do_clear(5'd3);
        for (int i = 0; i < 3; i++) begin
            run_step(cyc);
            checks++; if (accOut !== exp_edge[i]) begin failures++; $display("[TB] FAIL sat_edge[%0d] got=%0d exp=%0d", i, accOut, exp_edge[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        clear_mem();
        samp_mem[0] = 16'sd3; wgt_mem[0] = 16'sd1;
        samp_mem[1] = 16'sd4; wgt_mem[1] = 16'sd1;
        samp_mem[2] = 16'sd9; wgt_mem[2] = 16'sd9;
        do_clear(5'd2);
        startAdd = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (sinAddFin === 1'b1) pulses++;
        end
        startAdd = 1'b0;
        checks++; if (pulses != 2) begin failures++; $display("[TB] FAIL held_pulses got=%0d exp=2", pulses); end
        checks++; if (idx !== 5'd2) begin failures++; $display("[TB] FAIL held_idx got=%0d exp=2", idx); end
        checks++; if (accOut !== 24'sd7) begin failures++; $display("[TB] FAIL held_acc got=%0d exp=7", accOut); end
        checks++; if (lastAdd !== 1'b1) begin failures++; $display("[TB] FAIL held_last got=%b exp=1", lastAdd); end
    endtask

    task automatic test_clear_abort();
        int cyc;
        int pulses;
        clear_mem();
        samp_mem[0] = 16'sd2;  wgt_mem[0] = 16'sd5;
        samp_mem[1] = -16'sd3; wgt_mem[1] = 16'sd6;
        do_clear(5'd3);
        run_step(cyc);
        @(negedge clk);
        startAdd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startAdd = 1'b0;
        @(negedge clk);
        clear     = 1'b1;
        numInputs = 5'd3;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        checks++; if (accOut !== 24'sd0) begin failures++; $display("[TB] FAIL abort_acc got=%0d exp=0", accOut); end
        checks++; if (idx !== 5'd0) begin failures++; $display("[TB] FAIL abort_idx got=%0d exp=0", idx); end
        pulses = (sinAddFin === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (sinAddFin === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL abort_pulses got=%0d exp=0", pulses); end
        run_step(cyc);
        checks++; if (cyc != 3) begin failures++; $display("[TB] FAIL abort_restart_latency got=%0d exp=3", cyc); end
        checks++; if (accOut !== 24'sd10) begin failures++; $display("[TB] FAIL abort_restart_acc got=%0d exp=10", accOut); end
        @(negedge clk);
        clear     = 1'b1;
        startAdd  = 1'b1;
        numInputs = 5'd3;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        startAdd = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (sinAddFin === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL clear_start_pulses got=%0d exp=0", pulses); end
        checks++; if (idx !== 5'd0) begin failures++; $display("[TB] FAIL clear_start_idx got=%0d exp=0", idx); end
        checks++; if (accOut !== 24'sd0) begin failures++; $display("[TB] FAIL clear_start_acc got=%0d exp=0", accOut); end
    endtask

    task automatic test_zero_inputs();
        int pulses;
        checks++; if (lastAdd !== 1'b0) begin failures++; $display("[TB] FAIL zero_pre_last got=%b exp=0", lastAdd); end
        do_clear(5'd0);
        checks++; if (lastAdd !== 1'b1) begin failures++; $display("[TB] FAIL zero_last got=%b exp=1", lastAdd); end
        startAdd = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (sinAddFin === 1'b1) pulses++;
        end
        startAdd = 1'b0;
        checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL zero_pulses got=%0d exp=0", pulses); end
        checks++; if (idx !== 5'd0) begin failures++; $display("[TB] FAIL zero_idx got=%0d exp=0", idx); end
    endtask

    task automatic test_async_reset();
        int cyc;
        clear_mem();
        samp_mem[0] = 16'sd2;  wgt_mem[0] = 16'sd5;
        samp_mem[1] = -16'sd3; wgt_mem[1] = 16'sd6;
        do_clear(5'd3);
        run_step(cyc);
        @(negedge clk);
        checks++; if (accOut !== 24'sd10) begin failures++; $display("[TB] FAIL arst_pre_acc got=%0d exp=10", accOut); end
        startAdd = 1'b1;
        @(posedge clk);
        #2;
        startAdd = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (idx !== 5'd0) begin failures++; $display("[TB] FAIL arst_idx got=%0d exp=0", idx); end
        checks++; if (accOut !== 24'sd0) begin failures++; $display("[TB] FAIL arst_acc got=%0d exp=0", accOut); end
        checks++; if (sinAddFin !== 1'b0) begin failures++; $display("[TB] FAIL arst_fin got=%b exp=0", sinAddFin); end
        checks++; if (lastAdd !== 1'b1) begin failures++; $display("[TB] FAIL arst_last got=%b exp=1", lastAdd); end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (sinAddFin !== 1'b0 || idx !== 5'd0) begin failures++; $display("[TB] FAIL arst_idle fin=%b idx=%0d exp fin=0 idx=0", sinAddFin, idx); end
    endtask

    // Test sequence.
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        clear     = 1'b0;
        startAdd  = 1'b0;
        numInputs = 5'd0;
        clear_mem();
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_clear_abort();
        test_zero_inputs();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
